// File: rtl/ring_osc_pkg.sv
// Shared types and helpers for the ring oscillator trim controller.
// Holds the controller state encoding and the code-to-thermometer mapping.
package ring_osc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        MEASURE,
        ADJUST
    } state_t;

    localparam int TRIM_W   = 26;
    localparam int CODE_MAX = 26;
    localparam int CODE_W   = 5;

    // Thermometer: the low c bits set, primary bits fill before secondary.
    function automatic logic [TRIM_W-1:0] code_to_trim(
        input logic [CODE_W-1:0] c
    );
        logic [TRIM_W-1:0] t;
        t = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Synchronises the divided oscillator clock and counts its rising edges.
// The count saturates at all-ones; count_next is the value after this edge.
module osc_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             osc_div_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count_next
);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic [CNT_W-1:0] count;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= osc_div_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // Clear wins over counting; counting stops at all-ones.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (count_en && rise && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    // Edge count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/ring_osc_trim_ctrl.sv
// Frequency-locked trim loop for the 13-stage ring oscillator.
// Counts divided-clock edges per window and steps a thermometer trim.
module ring_osc_trim_ctrl
    import ring_osc_pkg::*;
#(
    parameter int WINDOW        = 1024,
    parameter int CNT_W         = 16,
    parameter int TOL           = 2,
    parameter int LOCK_HITS     = 4,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              manual_mode,
    input  logic [CODE_W-1:0] manual_code,
    input  logic [CNT_W-1:0]  target_count,
    input  logic              osc_div_in,
    output logic [TRIM_W-1:0] trim,
    output logic              osc_reset,
    output logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  meas_count,
    output logic              locked,
    output logic              saturated,
    output logic              busy
);

    localparam int TMAX_A = (WINDOW > RST_CYCLES) ? WINDOW : RST_CYCLES;
    localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);
    localparam int HIT_W  = $clog2(LOCK_HITS + 1);

    localparam logic [CODE_W-1:0] CMAX = CODE_W'(CODE_MAX);
    localparam logic [HIT_W-1:0]  HMAX = HIT_W'(LOCK_HITS);

    state_t             state;
    state_t             state_n;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_n;
    logic [CODE_W-1:0]  code_n;
    logic [HIT_W-1:0]   hits;
    logic [HIT_W-1:0]   hits_n;
    logic               locked_n;
    logic               sat_n;
    logic               clear;
    logic               count_en;
    logic               latch;
    logic [CODE_W-1:0]  man_tgt;
    logic [CNT_W:0]     band_hi;
    logic [CNT_W:0]     band_lo;
    logic [CNT_W:0]     meas_x;
    logic [CNT_W-1:0]   count_next;

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .osc_div_in (osc_div_in),
        .clear      (clear),
        .count_en   (count_en),
        .count_next (count_next)
    );

    // Lock band limits, one bit wider than the count; low edge clamps at 0.
    always_comb begin
        meas_x  = {1'b0, meas_count};
        band_hi = {1'b0, target_count} + (CNT_W+1)'(TOL);
        band_lo = '0;
        if (target_count >= CNT_W'(TOL)) begin
            band_lo = {1'b0, target_count} - (CNT_W+1)'(TOL);
        end
        man_tgt = (manual_code > CMAX) ? CMAX : manual_code;
    end

    // Next state, timer, trim code and lock bookkeeping.
    always_comb begin
        state_n  = state;
        timer_n  = timer + 1'b1;
        code_n   = code;
        hits_n   = hits;
        locked_n = locked;
        sat_n    = saturated;
        clear    = 1'b0;
        count_en = 1'b0;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (enable) state_n = START;
            end
            START: begin
                if (timer == TMR_W'(RST_CYCLES - 1)) begin
                    state_n = SETTLE;
                    timer_n = '0;
                end
            end
            SETTLE: begin
                if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
                    clear   = 1'b1;
                    state_n = MEASURE;
                    timer_n = '0;
                end
            end
            MEASURE: begin
                count_en = 1'b1;
                if (timer == TMR_W'(WINDOW - 1)) begin
                    latch   = 1'b1;
                    state_n = ADJUST;
                    timer_n = '0;
                end
            end
            ADJUST: begin
                state_n = SETTLE;
                timer_n = '0;
                if (!manual_mode) begin
                    unique case (1'b1)
                        (meas_x > band_hi): begin
                            hits_n   = '0;
                            locked_n = 1'b0;
                            if (code == CMAX) sat_n = 1'b1;
                            else code_n = code + 1'b1;
                        end
                        (meas_x < band_lo): begin
                            hits_n   = '0;
                            locked_n = 1'b0;
                            if (code == '0) sat_n = 1'b1;
                            else code_n = code - 1'b1;
                        end
                        default: begin
                            sat_n    = 1'b0;
                            hits_n   = (hits == HMAX) ? hits : hits + 1'b1;
                            locked_n = (hits_n == HMAX);
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
        if (manual_mode && (state inside {SETTLE, MEASURE, ADJUST})) begin
            locked_n = 1'b0;
            hits_n   = '0;
            if (code < man_tgt) code_n = code + 1'b1;
            else if (code > man_tgt) code_n = code - 1'b1;
        end
        if (!enable) begin
            state_n  = IDLE;
            timer_n  = '0;
            hits_n   = '0;
            locked_n = 1'b0;
            sat_n    = 1'b0;
        end
    end

    // State and output registers; trim tracks the code one bit per step.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            code       <= '0;
            hits       <= '0;
            locked     <= 1'b0;
            saturated  <= 1'b0;
            meas_count <= '0;
            trim       <= '0;
            osc_reset  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            code      <= code_n;
            hits      <= hits_n;
            locked    <= locked_n;
            saturated <= sat_n;
            if (latch) meas_count <= count_next;
            trim      <= code_to_trim(code_n);
            osc_reset <= (state_n == IDLE) || (state_n == START);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Scoreboard bench for ring_osc_trim_ctrl with a behavioural oscillator.
// The window is lengthened so 600 edges per window stay below Nyquist.
module tb_ring_osc_trim_ctrl;

    localparam int WIN  = 2048;
    localparam int RSTC = 16;
    localparam int SETC = 8;
    localparam int LOOP = SETC + WIN + 1;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        manual_mode;
    logic [4:0]  manual_code;
    logic [15:0] target_count;
    logic        osc_div_in;
    logic [25:0] trim;
    logic        osc_reset;
    logic [4:0]  code;
    logic [15:0] meas_count;
    logic        locked;
    logic        saturated;
    logic        busy;

    ring_osc_trim_ctrl #(
        .WINDOW        (WIN),
        .CNT_W         (16),
        .TOL           (2),
        .LOCK_HITS     (4),
        .RST_CYCLES    (RSTC),
        .SETTLE_CYCLES (SETC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .manual_mode  (manual_mode),
        .manual_code  (manual_code),
        .target_count (target_count),
        .osc_div_in   (osc_div_in),
        .trim         (trim),
        .osc_reset    (osc_reset),
        .code         (code),
        .meas_count   (meas_count),
        .locked       (locked),
        .saturated    (saturated),
        .busy         (busy)
    );

    typedef struct {
        string       tag;
        bit [6:0]    m;
        logic [4:0]  code;
        logic [25:0] trim;
        logic        osr;
        logic        lck;
        logic        sat;
        logic        bsy;
        int          mlo;
        int          mhi;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [25:0] therm(input int c);
        logic [25:0] t;
        t = '0;
        for (int i = 0; i < c; i++) t[i] = 1'b1;
        return t;
    endfunction

    // Oscillator model: 600 - 20*code rising edges per window.
    initial begin
        int acc;
        int rate;
        acc = 0;
        osc_div_in = 1'b0;
        forever begin
            @(negedge clock);
            rate = 600 - 20 * $countones(trim);
            acc = (acc + rate) % WIN;
            osc_div_in = (acc >= WIN / 2);
        end
    end

    task automatic push(input string tag, input bit [6:0] m,
                        input int c, input logic [25:0] t,
                        input logic osr, input logic lck,
                        input logic sat, input logic bsy,
                        input int mlo, input int mhi);
        exp_t e;
        e.tag = tag; e.m = m; e.code = 5'(c); e.trim = t;
        e.osr = osr; e.lck = lck; e.sat = sat; e.bsy = bsy;
        e.mlo = mlo; e.mhi = mhi;
        q.push_back(e);
    endtask

    task automatic chk_int(input string tag, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, req);
        end
    endtask

    // which: 0 code==val, 1 locked, 2 saturated
    task automatic wait_for(input string tag, input int which, input int val,
                            input int lim, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < lim) begin
            @(negedge clock);
            n++;
            case (which)
                0: hit = (int'(code) == val);
                1: hit = locked;
                default: hit = saturated;
            endcase
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", tag, n);
            n = -1;
        end
    endtask

    // Monitor: compare each queued expectation against the live outputs.
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(negedge clock);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                ok = 1;
                if (e.m[0] && code !== e.code) ok = 0;
                if (e.m[1] && trim !== e.trim) ok = 0;
                if (e.m[2] && osc_reset !== e.osr) ok = 0;
                if (e.m[3] && locked !== e.lck) ok = 0;
                if (e.m[4] && saturated !== e.sat) ok = 0;
                if (e.m[5] && busy !== e.bsy) ok = 0;
                if (e.m[6] && (int'(meas_count) < e.mlo ||
                               int'(meas_count) > e.mhi)) ok = 0;
                n_chk++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: got code=%0d trim=%h osc_reset=%b locked=%b sat=%b busy=%b meas=%0d; want code=%0d trim=%h osc_reset=%b locked=%b sat=%b busy=%b meas=%0d..%0d mask=%b",
                             e.tag, code, trim, osc_reset, locked, saturated,
                             busy, meas_count, e.code, e.trim, e.osr, e.lck,
                             e.sat, e.bsy, e.mlo, e.mhi, e.m);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        int cnt;
        bit done;
        reset = 1'b1;
        enable = 1'b0;
        manual_mode = 1'b0;
        manual_code = '0;
        target_count = 16'd400;
        repeat (3) @(negedge clock);
        push("reset_vals", 7'h7F, 0, '0, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        push("idle_after_reset", 7'h7F, 0, '0, 1, 0, 0, 0, 0, 0);

        enable = 1'b1;
        cnt = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (busy && osc_reset) cnt++;
            else if (busy) done = 1;
        end
        chk_int("osc_reset_cycles", cnt, RSTC);
        push("start_release", 7'b0100111, 0, '0, 0, 0, 0, 1, 0, 0);

        wait_for("reach_code10", 0, 10, 40000, n);
        push("code10_unlocked", 7'b0011011, 10, 26'h3FF, 0, 0, 0, 0, 0, 0);
        wait_for("lock", 1, 1, 5 * LOOP, n);
        chk_int("lock_latency", n, 4 * LOOP);
        push("locked_code10", 7'h7F, 10, 26'h3FF, 0, 1, 0, 1, 399, 401);

        target_count = 16'd1000;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        wait_for("slow_sat", 2, 1, 3000, n);
        chk_int("slow_sat_latency", n, 1 + RSTC + LOOP);
        push("slow_sat", 7'b1011011, 0, '0, 0, 0, 1, 0, 599, 601);
        repeat (LOOP) @(negedge clock);
        push("slow_sat_hold", 7'b1011011, 0, '0, 0, 0, 1, 0, 599, 601);

        manual_mode = 1'b1;
        manual_code = 5'd3;
        repeat (3) @(negedge clock);
        push("manual_to3", 7'b0001011, 3, therm(3), 0, 0, 0, 0, 0, 0);
        manual_code = 5'd31;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock);
            n = (3 + k > 26) ? 26 : 3 + k;
            push("manual_slew", 7'b0001011, n, therm(n), 0, 0, 0, 0, 0, 0);
        end

        manual_mode = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        push("idle_keeps_code", 7'b0111111, 26, 26'h3FFFFFF, 1, 0, 0, 0, 0, 0);

        target_count = 16'd10;
        enable = 1'b1;
        wait_for("fast_sat", 2, 1, 3000, n);
        chk_int("fast_sat_latency", n, 1 + RSTC + LOOP);
        push("fast_sat", 7'h7F, 26, 26'h3FFFFFF, 0, 0, 1, 1, 79, 81);

        repeat (SETC + 300) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        push("drop_enable", 7'h7F, 26, 26'h3FFFFFF, 1, 0, 0, 0, 79, 81);

        enable = 1'b1;
        repeat (1 + RSTC + SETC + 500) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push("reset_mid_window", 7'h7F, 0, '0, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        push("idle_final", 7'h7F, 0, '0, 1, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
